// File: rtl/snes_rom_pkg.sv
// snes_rom_pkg
// Shared definitions for the SNES ROM header detector: memory-map and FSM
// enums, header locations inside the ROM image, the map-mode nibble each
// candidate expects, the size-byte limits, and the per-candidate header
// fields handed from a candidate to the selector.
package snes_rom_pkg;

  typedef enum logic [1:0] {
    MAP_LO   = 2'd0,
    MAP_HI   = 2'd1,
    MAP_EXHI = 2'd2
  } map_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SCORE,
    S_COMMIT
  } state_e;

  // Header base addresses inside the ROM image (excluding the stream offset)
  localparam logic [24:0] HDR_OFS_LO   = 25'h007FC0;
  localparam logic [24:0] HDR_OFS_HI   = 25'h00FFC0;
  localparam logic [24:0] HDR_OFS_EXHI = 25'h40FFC0;

  // A header past the end of the image is not trusted: the image must reach
  // at least this size for the candidate to score
  localparam logic [24:0] MIN_IMG_HI   = 25'h010000;
  localparam logic [24:0] MIN_IMG_EXHI = 25'h410000;

  // Low nibble of the map-mode byte a genuine header carries
  localparam logic [3:0] MAP_NIB_LO   = 4'h0;
  localparam logic [3:0] MAP_NIB_HI   = 4'h1;
  localparam logic [3:0] MAP_NIB_EXHI = 4'h5;

  // Size-byte limits
  localparam logic [7:0] ROMSZ_MIN = 8'h08;
  localparam logic [7:0] ROMSZ_MAX = 8'h0D;
  localparam logic [7:0] ROMSZ_DEF = 8'h0C;
  localparam logic [7:0] RAMSZ_MAX = 8'h07;

  // Header fields that feed the outputs (only the upper chip nibble is used)
  typedef struct packed {
    logic [3:0] chip_hi;
    logic [7:0] romsz;
    logic [7:0] ramsz;
    logic [7:0] region;
  } hdr_t;

  localparam hdr_t HDR_DEFAULT = '{chip_hi: 4'h0, romsz: ROMSZ_DEF,
                                   ramsz: 8'h00, region: 8'h00};

endpackage

// File: rtl/rom_hdr_cand.sv
// rom_hdr_cand
// Captures one candidate header out of the download stream and scores it.
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_clr      : synchronous clear of all captures (start of a new download)
//   i_wr       : qualified write strobe (already gated by download/LOAD)
//   i_addr     : byte address of the stream word (even)
//   i_din      : stream word, [7:0] at i_addr, [15:8] at i_addr+1
//   i_last     : highest address written so far in this download
//   o_hdr      : captured fields, defaults substituted for missing words
//   o_score    : 0..8 plausibility score, 0 when incomplete or image too short
module rom_hdr_cand
  import snes_rom_pkg::*;
#(
  parameter logic [24:0] BASE     = 25'h0,
  parameter logic [3:0]  EXP_NIB  = 4'h0,
  parameter logic [24:0] MIN_LAST = 25'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_wr,
  input  logic [24:0] i_addr,
  input  logic [15:0] i_din,
  input  logic [24:0] i_last,
  output hdr_t        o_hdr,
  output logic [3:0]  o_score
);

  localparam logic [24:0] A_MAP  = BASE + 25'h14;
  localparam logic [24:0] A_CHIP = BASE + 25'h16;
  localparam logic [24:0] A_RAM  = BASE + 25'h18;
  localparam logic [24:0] A_CPL  = BASE + 25'h1C;
  localparam logic [24:0] A_SUM  = BASE + 25'h1E;

  logic [3:0]  r_map;
  logic [3:0]  r_chip_hi;
  logic [7:0]  r_romsz;
  logic [7:0]  r_ramsz;
  logic [7:0]  r_region;
  logic [15:0] r_cpl;
  logic [15:0] r_sum;
  // one valid per captured word: map, chip/romsz, ramsz/region, cpl, sum
  logic [4:0]  r_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_map     <= '0;
      r_chip_hi <= '0;
      r_romsz   <= '0;
      r_ramsz   <= '0;
      r_region  <= '0;
      r_cpl     <= '0;
      r_sum     <= '0;
      r_vld     <= '0;
    end else if (i_clr) begin
      r_map     <= '0;
      r_chip_hi <= '0;
      r_romsz   <= '0;
      r_ramsz   <= '0;
      r_region  <= '0;
      r_cpl     <= '0;
      r_sum     <= '0;
      r_vld     <= '0;
    end else if (i_wr) begin
      if (i_addr == A_MAP) begin
        r_map    <= i_din[11:8];
        r_vld[0] <= 1'b1;
      end
      if (i_addr == A_CHIP) begin
        r_chip_hi <= i_din[7:4];
        r_romsz   <= i_din[15:8];
        r_vld[1]  <= 1'b1;
      end
      if (i_addr == A_RAM) begin
        r_ramsz  <= i_din[7:0];
        r_region <= i_din[15:8];
        r_vld[2] <= 1'b1;
      end
      if (i_addr == A_CPL) begin
        r_cpl    <= i_din;
        r_vld[3] <= 1'b1;
      end
      if (i_addr == A_SUM) begin
        r_sum    <= i_din;
        r_vld[4] <= 1'b1;
      end
    end
  end

  logic [15:0] w_chk_sum;
  logic        w_chk_ok;
  logic        w_map_ok;
  logic        w_rom_ok;
  logic        w_ram_ok;
  logic [3:0]  w_raw;
  logic [25:0] w_last_diff;
  logic        w_short;

  assign w_chk_sum = r_cpl + r_sum;
  assign w_chk_ok  = (w_chk_sum == 16'hFFFF);
  assign w_map_ok  = (r_map == EXP_NIB);
  assign w_rom_ok  = (r_romsz >= ROMSZ_MIN) && (r_romsz <= ROMSZ_MAX);
  assign w_ram_ok  = (r_ramsz <= RAMSZ_MAX);
  assign w_raw     = (w_chk_ok ? 4'd4 : 4'd0) + (w_map_ok ? 4'd2 : 4'd0)
                   + {3'b000, w_rom_ok} + {3'b000, w_ram_ok};

  // Borrow out of LAST - MIN_LAST means the image ends before this header
  // could plausibly belong to it.
  assign w_last_diff = {1'b0, i_last} - {1'b0, MIN_LAST};
  assign w_short     = w_last_diff[25];

  assign o_score = ((&r_vld) && !w_short) ? w_raw : 4'd0;

  assign o_hdr.chip_hi = r_vld[1] ? r_chip_hi : HDR_DEFAULT.chip_hi;
  assign o_hdr.romsz   = r_vld[1] ? r_romsz   : HDR_DEFAULT.romsz;
  assign o_hdr.ramsz   = r_vld[2] ? r_ramsz   : HDR_DEFAULT.ramsz;
  assign o_hdr.region  = r_vld[2] ? r_region  : HDR_DEFAULT.region;

endmodule

// File: rtl/rom_header_detect.sv
// rom_header_detect
// Watches a ROM download stream, captures the LoROM/HiROM/ExHiROM header
// candidates, scores them once the download ends and publishes the memory
// map, ROM/RAM address masks and region.
//   CLK      : clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   DL       : download active
//   WR       : one-cycle write strobe
//   ADDR     : byte address of the stream word (even)
//   DIN      : stream word, [7:0] at ADDR, [15:8] at ADDR+1
//   FORCE    : 0 auto, 1 LoROM, 2 HiROM, 3 ExHiROM (sampled when DL falls)
//   ROM_TYPE : [7:4] chip nibble, [1:0] map
//   ROM_MASK : ROM address mask
//   RAM_MASK : backup RAM mask, 0 when none
//   REGION   : 1 = PAL
//   DONE     : one-cycle pulse when the outputs update
module rom_header_detect
  import snes_rom_pkg::*;
#(
  parameter int unsigned DATA_OFS = 512
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        DL,
  input  logic        WR,
  input  logic [24:0] ADDR,
  input  logic [15:0] DIN,
  input  logic [1:0]  FORCE,
  output logic [7:0]  ROM_TYPE,
  output logic [23:0] ROM_MASK,
  output logic [23:0] RAM_MASK,
  output logic        REGION,
  output logic        DONE
);

  localparam logic [24:0] P_OFS       = 25'(DATA_OFS);
  localparam logic [24:0] P_BASE_LO   = P_OFS + HDR_OFS_LO;
  localparam logic [24:0] P_BASE_HI   = P_OFS + HDR_OFS_HI;
  localparam logic [24:0] P_BASE_EXHI = P_OFS + HDR_OFS_EXHI;

  function automatic logic [7:0] clamp_romsz(input logic [7:0] sz);
    if (sz < ROMSZ_MIN) return ROMSZ_MIN;
    if (sz > ROMSZ_MAX) return ROMSZ_MAX;
    return sz;
  endfunction

  function automatic logic [23:0] rom_mask_of(input logic [7:0] sz);
    return 24'((32'd1024 << clamp_romsz(sz)) - 32'd1);
  endfunction

  function automatic logic [23:0] ram_mask_of(input logic [7:0] sz);
    logic [7:0] n;
    n = (sz > RAMSZ_MAX) ? RAMSZ_MAX : sz;
    if (sz == 8'h00) return 24'h000000;
    return 24'((32'd1024 << n) - 32'd1);
  endfunction

  function automatic logic is_pal(input logic [7:0] r);
    return (r >= 8'h02) && (r <= 8'h0C);
  endfunction

  state_e      r_state;
  state_e      w_state_nx;
  logic        r_dl_q;
  logic [1:0]  r_idx;
  logic [1:0]  r_force;
  logic [24:0] r_last;
  logic [1:0]  r_best;
  logic [3:0]  r_best_sc;
  logic [7:0]  r_rom_type;
  logic [23:0] r_rom_mask;
  logic [23:0] r_ram_mask;
  logic        r_region;
  logic        r_done;

  logic        w_dl_rise;
  logic        w_dl_fall;
  logic        w_wr;
  logic        w_commit;
  hdr_t        w_hdr_lo;
  hdr_t        w_hdr_hi;
  hdr_t        w_hdr_exhi;
  logic [3:0]  w_sc_lo;
  logic [3:0]  w_sc_hi;
  logic [3:0]  w_sc_exhi;
  logic [1:0]  w_fin_map;
  logic [3:0]  w_fin_sc;
  logic [1:0]  w_map;
  logic        w_use_def;
  hdr_t        w_hdr;

  assign w_dl_rise = DL & ~r_dl_q;
  assign w_dl_fall = ~DL & r_dl_q;
  assign w_wr      = WR & DL & (r_state == S_LOAD);
  // DONE is registered on entry to COMMIT, so a new download can only
  // cancel the pulse up to the last SCORE cycle.
  assign w_commit  = (r_state == S_SCORE) && (r_idx == 2'd2) && !w_dl_rise;

  rom_hdr_cand #(
    .BASE(P_BASE_LO), .EXP_NIB(MAP_NIB_LO), .MIN_LAST(25'h0)
  ) u_cand_lo (
    .i_clk(CLK), .i_rst_n(RESET_N), .i_clr(w_dl_rise), .i_wr(w_wr),
    .i_addr(ADDR), .i_din(DIN), .i_last(r_last),
    .o_hdr(w_hdr_lo), .o_score(w_sc_lo)
  );

  rom_hdr_cand #(
    .BASE(P_BASE_HI), .EXP_NIB(MAP_NIB_HI), .MIN_LAST(P_OFS + MIN_IMG_HI)
  ) u_cand_hi (
    .i_clk(CLK), .i_rst_n(RESET_N), .i_clr(w_dl_rise), .i_wr(w_wr),
    .i_addr(ADDR), .i_din(DIN), .i_last(r_last),
    .o_hdr(w_hdr_hi), .o_score(w_sc_hi)
  );

  rom_hdr_cand #(
    .BASE(P_BASE_EXHI), .EXP_NIB(MAP_NIB_EXHI), .MIN_LAST(P_OFS + MIN_IMG_EXHI)
  ) u_cand_exhi (
    .i_clk(CLK), .i_rst_n(RESET_N), .i_clr(w_dl_rise), .i_wr(w_wr),
    .i_addr(ADDR), .i_din(DIN), .i_last(r_last),
    .o_hdr(w_hdr_exhi), .o_score(w_sc_exhi)
  );

  always_comb begin
    w_state_nx = r_state;
    if (w_dl_rise) begin
      w_state_nx = S_LOAD;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nx = S_IDLE;
        S_LOAD:   if (w_dl_fall) w_state_nx = S_SCORE;
        S_SCORE:  if (r_idx == 2'd2) w_state_nx = S_COMMIT;
        S_COMMIT: w_state_nx = S_IDLE;
        default:  w_state_nx = S_IDLE;
      endcase
    end
  end

  // Final pick: the ExHi candidate is folded in combinationally during the
  // last SCORE cycle; strict '>' keeps ties on the lower map index.
  always_comb begin
    w_fin_map = r_best;
    w_fin_sc  = r_best_sc;
    if (w_sc_exhi > r_best_sc) begin
      w_fin_map = MAP_EXHI;
      w_fin_sc  = w_sc_exhi;
    end
    w_use_def = 1'b0;
    if (r_force != 2'd0) begin
      w_map = r_force - 2'd1;
    end else begin
      w_map     = w_fin_map;
      w_use_def = (w_fin_sc == 4'd0);
    end
    case (w_map)
      MAP_HI:   w_hdr = w_hdr_hi;
      MAP_EXHI: w_hdr = w_hdr_exhi;
      default:  w_hdr = w_hdr_lo;
    endcase
    if (w_use_def) w_hdr = HDR_DEFAULT;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      // Start "high" so a DL already asserted across reset is not taken as
      // a fresh download.
      r_dl_q    <= 1'b1;
      r_idx     <= '0;
      r_force   <= '0;
      r_last    <= '0;
      r_best    <= MAP_LO;
      r_best_sc <= '0;
    end else begin
      r_state <= w_state_nx;
      r_dl_q  <= DL;
      if (w_dl_rise) begin
        r_last <= '0;
      end else if (w_wr && (ADDR > r_last)) begin
        r_last <= ADDR;
      end
      if ((r_state == S_LOAD) && w_dl_fall) begin
        r_force <= FORCE;
        r_idx   <= '0;
      end else if (r_state == S_SCORE) begin
        r_idx <= r_idx + 2'd1;
        case (r_idx)
          2'd0: begin
            r_best    <= MAP_LO;
            r_best_sc <= w_sc_lo;
          end
          2'd1: begin
            if (w_sc_hi > r_best_sc) begin
              r_best    <= MAP_HI;
              r_best_sc <= w_sc_hi;
            end
          end
          default: begin
            r_best    <= r_best;
            r_best_sc <= r_best_sc;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rom_type <= 8'h00;
      r_rom_mask <= 24'h3FFFFF;
      r_ram_mask <= 24'h000000;
      r_region   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_commit) begin
        r_rom_type <= {w_hdr.chip_hi, 2'b00, w_map};
        r_rom_mask <= rom_mask_of(w_hdr.romsz);
        r_ram_mask <= ram_mask_of(w_hdr.ramsz);
        r_region   <= is_pal(w_hdr.region);
      end
    end
  end

  assign ROM_TYPE = r_rom_type;
  assign ROM_MASK = r_rom_mask;
  assign RAM_MASK = r_ram_mask;
  assign REGION   = r_region;
  assign DONE     = r_done;

endmodule

// File: tb/tb_rom_header_detect.sv
// tb_rom_header_detect
// Scoreboard bench: each download pushes its expected result when DL drops;
// a monitor on the falling clock edge pops and compares on every DONE.
module tb_rom_header_detect;

  localparam int unsigned OFS = 512;

  logic        CLK;
  logic        RESET_N;
  logic        DL;
  logic        WR;
  logic [24:0] ADDR;
  logic [15:0] DIN;
  logic [1:0]  FORCE;
  logic [7:0]  ROM_TYPE;
  logic [23:0] ROM_MASK;
  logic [23:0] RAM_MASK;
  logic        REGION;
  logic        DONE;

  rom_header_detect #(.DATA_OFS(OFS)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DL(DL), .WR(WR), .ADDR(ADDR), .DIN(DIN),
    .FORCE(FORCE), .ROM_TYPE(ROM_TYPE), .ROM_MASK(ROM_MASK),
    .RAM_MASK(RAM_MASK), .REGION(REGION), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  rtype;
    logic [23:0] rmask;
    logic [23:0] amask;
    logic        region;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("rom_type", ROM_TYPE, mon_e.rtype);
        chk("rom_mask", ROM_MASK, mon_e.rmask);
        chk("ram_mask", RAM_MASK, mon_e.amask);
        chk("region", REGION, mon_e.region);
        chk("done_latency", cyc, mon_e.due);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [24:0] a, input logic [15:0] d);
    WR = 1'b1; ADDR = a; DIN = d;
    tick();
    WR = 1'b0;
  endtask

  task automatic dl_start();
    DL = 1'b1;
    tick();
  endtask

  task automatic hdr(input logic [24:0] ofs, input logic [7:0] map, input logic [7:0] chip,
                     input logic [7:0] romsz, input logic [7:0] ramsz,
                     input logic [7:0] region, input logic [15:0] cpl, input logic [15:0] sum);
    logic [24:0] b;
    b = 25'(OFS) + ofs;
    wr(b + 25'h14, {map, 8'h00});
    wr(b + 25'h16, {romsz, chip});
    wr(b + 25'h18, {region, ramsz});
    wr(b + 25'h1C, cpl);
    wr(b + 25'h1E, sum);
  endtask

  task automatic img_end(input logic [24:0] size);
    wr(25'(OFS) + size - 25'd2, 16'hFFFF);
  endtask

  task automatic dl_end(input logic [1:0] f, input logic [7:0] rt, input logic [23:0] rm,
                        input logic [23:0] am, input logic rg);
    exp_t e;
    FORCE = f;
    DL = 1'b0;
    e.rtype = rt; e.rmask = rm; e.amask = am; e.region = rg;
    e.due = cyc + 4;
    q.push_back(e);
    for (int i = 0; i < 12 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      q.delete();
    end
    FORCE = 2'd0;
    tick();
  endtask

  task automatic lo_1mb();
    hdr(25'h007FC0, 8'h20, 8'h00, 8'h0A, 8'h03, 8'h00, 16'h1234, 16'hEDCB);
    img_end(25'h100000);
  endtask

  task automatic hi_4mb();
    hdr(25'h00FFC0, 8'h21, 8'h35, 8'h0C, 8'h05, 8'h00, 16'hAAAA, 16'h5555);
    img_end(25'h400000);
  endtask

  task automatic exhi_6mb();
    hdr(25'h40FFC0, 8'h25, 8'hF5, 8'h0D, 8'h00, 8'h02, 16'h0F0F, 16'hF0F0);
    img_end(25'h600000);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; DL = 1'b0; WR = 1'b0; ADDR = '0; DIN = '0; FORCE = 2'd0;
    repeat (2) @(negedge CLK);
    chk("rst_rom_type", ROM_TYPE, 8'h00);
    chk("rst_rom_mask", ROM_MASK, 24'h3FFFFF);
    chk("rst_ram_mask", RAM_MASK, 24'h000000);
    chk("rst_region", REGION, 1'b0);
    chk("rst_done", DONE, 1'b0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    tick(); tick();

    // Valid LoROM, 1 MB
    dl_start(); lo_1mb();
    dl_end(2'd0, 8'h00, 24'h0FFFFF, 24'h001FFF, 1'b0);

    // Same image forced to HiROM: Hi header absent -> defaults
    dl_start(); lo_1mb();
    dl_end(2'd2, 8'h01, 24'h3FFFFF, 24'h000000, 1'b0);

    // HiROM 4 MB with garbage at the Lo location
    dl_start();
    hdr(25'h007FC0, 8'h7F, 8'h12, 8'hFF, 8'hFF, 8'h33, 16'h1111, 16'h1111);
    hi_4mb();
    dl_end(2'd0, 8'h31, 24'h3FFFFF, 24'h007FFF, 1'b0);

    // ExHiROM 6 MB, PAL
    dl_start(); exhi_6mb();
    dl_end(2'd0, 8'hF2, 24'h7FFFFF, 24'h000000, 1'b1);

    // Reset in the middle of a load: outputs held, then reset, no DONE
    dl_start();
    hdr(25'h007FC0, 8'h20, 8'h00, 8'h0A, 8'h03, 8'h00, 16'h1234, 16'hEDCB);
    chk("hold_rom_mask", ROM_MASK, 24'h7FFFFF);
    chk("hold_region", REGION, 1'b1);
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_rom_type", ROM_TYPE, 8'h00);
    chk("midrst_rom_mask", ROM_MASK, 24'h3FFFFF);
    chk("midrst_region", REGION, 1'b0);
    #2 RESET_N = 1'b1;
    tick();
    img_end(25'h100000);
    DL = 1'b0;
    repeat (8) tick();
    chk("postrst_rom_mask", ROM_MASK, 24'h3FFFFF);
    chk("postrst_ram_mask", RAM_MASK, 24'h000000);

    // Next full download after the reset completes normally
    dl_start(); lo_1mb();
    dl_end(2'd0, 8'h00, 24'h0FFFFF, 24'h001FFF, 1'b0);

    // Lo and Hi both score 8: tie goes to LoROM; ramsz 7, region 0x0C
    dl_start();
    hdr(25'h007FC0, 8'h20, 8'h10, 8'h09, 8'h07, 8'h0C, 16'h0000, 16'hFFFF);
    hdr(25'h00FFC0, 8'h31, 8'h20, 8'h0B, 8'h01, 8'h0D, 16'hFFFF, 16'h0000);
    img_end(25'h400000);
    dl_end(2'd0, 8'h10, 24'h07FFFF, 24'h01FFFF, 1'b1);

    // Valid Hi header but the image stops short of 64 KB: all scores 0
    dl_start();
    hdr(25'h00FFC0, 8'h21, 8'h50, 8'h0C, 8'h00, 8'h00, 16'h1234, 16'hEDCB);
    dl_end(2'd0, 8'h00, 24'h3FFFFF, 24'h000000, 1'b0);

    // Forced LoROM on garbage: upper clamps
    dl_start();
    hdr(25'h007FC0, 8'h7F, 8'h12, 8'hFF, 8'hFF, 8'h33, 16'h1111, 16'h1111);
    img_end(25'h400000);
    dl_end(2'd1, 8'h10, 24'h7FFFFF, 24'h01FFFF, 1'b0);

    // Forced ExHiROM: lower romsz clamp, smallest RAM, region lower bound
    dl_start();
    hdr(25'h40FFC0, 8'h00, 8'hA0, 8'h02, 8'h01, 8'h02, 16'h0000, 16'h0000);
    img_end(25'h600000);
    dl_end(2'd3, 8'hA2, 24'h03FFFF, 24'h0007FF, 1'b1);

    // DL re-raised one cycle after falling: abort, captures cleared
    dl_start(); lo_1mb();
    DL = 1'b0;
    tick();
    DL = 1'b1;
    tick();
    hi_4mb();
    dl_end(2'd0, 8'h31, 24'h3FFFFF, 24'h007FFF, 1'b0);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_header_detect.md
ROM_HEADER_DETECT -- requirements
Module: rom_header_detect

Interface
REQ-001 SHALL have parameter DATA_OFS, default 512, meaning the byte offset of ROM image data within the download stream.
REQ-002 SHALL have port CLK  in  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port RESET_N  in  1  asynchronous active-low reset.
REQ-004 SHALL have port DL  in  1  download active.
REQ-005 SHALL have port WR  in  1  one-cycle write strobe carrying a stream word.
REQ-006 SHALL have port ADDR  in  25  byte address of the word; always even.
REQ-007 SHALL have port DIN  in  16  stream word; [7:0] is byte ADDR and [15:8] is byte ADDR+1.
REQ-008 SHALL have port FORCE  in  2  map override: 0=auto, 1=LoROM, 2=HiROM, 3=ExHiROM.
REQ-009 SHALL have port ROM_TYPE  out  8  result type: [7:4]=chip byte [7:4], [3:2]=0, [1:0]=map (0 Lo, 1 Hi, 2 ExHi).
REQ-010 SHALL have port ROM_MASK  out  24  ROM address mask.
REQ-011 SHALL have port RAM_MASK  out  24  backup RAM mask; 0 means none.
REQ-012 SHALL have port REGION  out  1  region flag; 1=PAL.
REQ-013 SHALL have port DONE  out  1  one-cycle pulse when the outputs update.

Function
REQ-014 SHALL define header bases (image offset): Lo=0x007FC0, Hi=0x00FFC0, ExHi=0x40FFC0; stream address = DATA_OFS + image offset.
REQ-015 SHALL, per candidate, capture on WR with ADDR match: map byte = +0x15 (DIN[15:8] of word +0x14); chip = +0x16; romsz = +0x17; ramsz = +0x18; region byte = +0x19; cpl = word +0x1C; sum = word +0x1E (little-endian).
REQ-016 SHALL track LAST = highest ADDR written in the current download.
REQ-017 SHALL implement states IDLE, LOAD, SCORE, COMMIT.
REQ-018 Transitions: IDLE->LOAD on DL rising edge; LOAD->SCORE on DL falling edge; SCORE->COMMIT after exactly 3 cycles (one per candidate: Lo, Hi, ExHi); COMMIT->IDLE after 1 cycle.
REQ-019 SHALL, on DL rising edge in any state, clear all captures, all valid flags and LAST, then enter LOAD; this aborts SCORE or COMMIT with no DONE pulse.
REQ-020 SHALL compute each candidate's 4-bit score as the sum of:
- +4 if cpl+sum == 0xFFFF (16-bit);
- +2 if map[3:0] == expected (Lo 0x0, Hi 0x1, ExHi 0x5);
- +1 if romsz is in 0x08..0x0D;
- +1 if ramsz <= 0x07.
REQ-021 SHALL force a candidate's score to 0 if any of its fields were not captured; Hi SHALL also score 0 if LAST < DATA_OFS+0x10000, and ExHi if LAST < DATA_OFS+0x410000.
REQ-022 SHALL select, in auto mode, the highest score, ties going to the lower map index; if all scores are 0, LoROM with romsz=0x0C, ramsz=0, chip=0, region=0.
REQ-023 SHALL, when FORCE != 0, use the forced map and that candidate's fields (defaults of REQ-022 for any uncaptured field); FORCE is sampled on the DL falling edge.
REQ-024 SHALL clamp romsz to 0x08..0x0D and set ROM_MASK = (1024<<romsz)-1, e.g. 0x0D gives 0x7FFFFF.
REQ-025 SHALL set RAM_MASK = 0 if ramsz==0, else (1024<<min(ramsz,7))-1.
REQ-026 SHALL set REGION = 1 for a region byte in 0x02..0x0C, else 0.
REQ-027 SHALL register all outputs in COMMIT and assert DONE for that single cycle; latency from DL falling edge to DONE is 4 cycles.
REQ-028 SHALL hold the outputs through later LOAD and SCORE phases until the next COMMIT.
REQ-029 SHALL ignore WR while DL=0; the last capture wins on a repeated address.

Reset
REQ-030 SHALL, on RESET_N low, asynchronously set state=IDLE, ROM_TYPE=0, ROM_MASK=0x3FFFFF, RAM_MASK=0, REGION=0, DONE=0, and clear captures and LAST.
REQ-031 SHALL, on reset during LOAD, lose the load: no DONE pulse; a new DL rising edge is required.

Structure
REQ-032 SHALL place the map enum, the three header offsets, the expected map nibbles and the size clamp limits in package snes_rom_pkg.
REQ-033 SHALL implement capture and score for one candidate in sub-module rom_hdr_cand (parameters: base, expected nibble, minimum LAST), instantiated three times.

Verification
REQ-034 Valid LoROM header (map 0x20, romsz 0x0A, ramsz 0x03, cpl 0x1234, sum 0xEDCB), 1 MB image -> DONE 4 cycles after DL falls, ROM_TYPE=0x00, ROM_MASK=0x0FFFFF, RAM_MASK=0x001FFF.
REQ-035 HiROM 4 MB image with valid Hi header and garbage at Lo -> ROM_TYPE[1:0]=1, ROM_MASK=0x3FFFFF.
REQ-036 Valid ExHi header at 0x40FFC0, 6 MB image, romsz 0x0D, region 0x02 -> map=2, ROM_MASK=0x7FFFFF, REGION=1.
REQ-037 Same 1 MB LoROM image with FORCE=2 -> map=1 using Hi defaults (ROM_MASK=0x3FFFFF, RAM_MASK=0).
REQ-038 DL reasserted 1 cycle after falling -> no DONE; second load completes normally.
REQ-039 RESET_N pulsed mid-LOAD -> outputs at reset values, no DONE until the next full download.
